// File: rtl/pong_timing_pkg.sv
// pong_timing_pkg: default Pong raster constants and the shared 9-bit count type,
// reused by the timing top and by sprite/score blocks.
package pong_timing_pkg;
  localparam int COUNT_W = 9;
  typedef logic [COUNT_W-1:0] count_t;
  localparam int DEF_H_TOTAL     = 455;
  localparam int DEF_V_TOTAL     = 262;
  localparam int DEF_HBLANK_END  = 80;
  localparam int DEF_HSYNC_START = 32;
  localparam int DEF_HSYNC_END   = 64;
  localparam int DEF_VBLANK_END  = 16;
  localparam int DEF_VSYNC_START = 4;
  localparam int DEF_VSYNC_END   = 8;
  // Half-open window [lo, hi) on unsigned counts.
  function automatic logic in_window(count_t c, count_t lo, count_t hi);
    return (c >= lo) && (c < hi);
  endfunction
endpackage

// File: rtl/timing_counter.sv
// timing_counter: modulo-N counter with clock enable, async active-low reset,
// exposing the next value so downstream registers can align with the count.
module timing_counter
  import pong_timing_pkg::*;
#(
  parameter int N = 2
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   ce,
  output count_t count,
  output count_t next_count,
  output logic   terminal
);
  localparam count_t LAST = count_t'(N - 1);
  assign terminal   = (count == LAST);
  assign next_count = !ce ? count : terminal ? '0 : count + count_t'(1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) count <= '0;
    else        count <= next_count;
endmodule

// File: rtl/pong_video_timing.sv
// pong_video_timing: synchronous H/V raster sequencer producing counts, line/frame
// reset strobes and blank/sync levels aligned with the counts they describe.
module pong_video_timing
  import pong_timing_pkg::*;
#(
  parameter int H_TOTAL     = DEF_H_TOTAL,
  parameter int V_TOTAL     = DEF_V_TOTAL,
  parameter int HBLANK_END  = DEF_HBLANK_END,
  parameter int HSYNC_START = DEF_HSYNC_START,
  parameter int HSYNC_END   = DEF_HSYNC_END,
  parameter int VBLANK_END  = DEF_VBLANK_END,
  parameter int VSYNC_START = DEF_VSYNC_START,
  parameter int VSYNC_END   = DEF_VSYNC_END
) (
  input  logic   mclk,
  input  logic   _reset,
  input  logic   ce,
  output count_t hcount,
  output count_t vcount,
  output logic   _hreset,
  output logic   _vreset,
  output logic   hblank,
  output logic   _hblank,
  output logic   _hsync,
  output logic   vblank,
  output logic   _vblank,
  output logic   _vsync
);
  if (H_TOTAL < 2 || H_TOTAL > 512 || V_TOTAL < 2 || V_TOTAL > 512 ||
      HBLANK_END > 511 || HSYNC_START > 511 || HSYNC_END > 511 ||
      VBLANK_END > 511 || VSYNC_START > 511 || VSYNC_END > 511 ||
      HSYNC_END > HBLANK_END || VSYNC_END > VBLANK_END) begin : g_bad_params
    $error("pong_video_timing: illegal timing parameters");
  end
  localparam count_t HBE = count_t'(HBLANK_END);
  localparam count_t HSS = count_t'(HSYNC_START);
  localparam count_t HSE = count_t'(HSYNC_END);
  localparam count_t VBE = count_t'(VBLANK_END);
  localparam count_t VSS = count_t'(VSYNC_START);
  localparam count_t VSE = count_t'(VSYNC_END);
  count_t h_next, v_next;
  logic   h_term, v_term;
  timing_counter #(.N(H_TOTAL)) u_h (
    .clk(mclk), .rst_n(_reset), .ce(ce),
    .count(hcount), .next_count(h_next), .terminal(h_term)
  );
  // The frame counter steps only on the edge where the line counter wraps.
  timing_counter #(.N(V_TOTAL)) u_v (
    .clk(mclk), .rst_n(_reset), .ce(ce & h_term),
    .count(vcount), .next_count(v_next), .terminal(v_term)
  );
  assign _hreset = ~h_term;
  assign _vreset = ~(h_term & v_term);
  assign _hblank = ~hblank;
  assign _vblank = ~vblank;
  // Levels are registered from the next count so they line up with hcount/vcount.
  always_ff @(posedge mclk or negedge _reset)
    if (!_reset) begin
      hblank <= 1'b1;
      _hsync <= 1'b1;
      vblank <= 1'b1;
      _vsync <= 1'b1;
    end else begin
      hblank <= (h_next < HBE);
      _hsync <= ~in_window(h_next, HSS, HSE);
      vblank <= (v_next < VBE);
      _vsync <= ~in_window(v_next, VSS, VSE);
    end
endmodule
